// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared sizes, types and BCM helpers for the LED matrix scan driver
package led_matrix_pkg;
  localparam int SCAN_ROWS = 32;
  localparam int TIMER_W = $clog2(32 << 7) + 1;
  localparam int ROW_W = $clog2(SCAN_ROWS);
  localparam int PLANE_W = 3;
  typedef logic [23:0] rgb_t;
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [PLANE_W-1:0] plane;
  } tag_t;
  typedef enum logic {SHIFT, WAIT_LATCH} shift_state_t;
  typedef enum logic [1:0] {DISPLAY, BLANK, LATCH} disp_state_t;
  function automatic int plane_cycles(int base, int b);
    return base << b;
  endfunction
endpackage

// File: rtl/led_matrix_bcm_timer.sv
// led_matrix_bcm_timer: loadable down-counter whose expired flag ends a BCM interval
module led_matrix_bcm_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);
  logic [W-1:0] count;
  // count down to zero and park there; reset leaves the timer already expired
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (load) count <= value;
    else if (count != '0) count <= count - 1'b1;
  assign expired = (count == '0);
endmodule

// File: rtl/led_matrix_scan_driver.sv
// led_matrix_scan_driver: shifts BCM bit planes into a HUB75 panel and paces latch, OE and row address
module led_matrix_scan_driver
  import led_matrix_pkg::*;
#(
  parameter int PANEL_ROWS   = 64,
  parameter int PANEL_COLS   = 64,
  parameter int COLOR_DEPTH  = 8,
  parameter int BASE_CYCLES  = 32,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            line_sync,
  output logic [$clog2(PANEL_COLS)-1:0]   frame_column,
  input  logic [3*COLOR_DEPTH-1:0]        rgb_in_upper,
  input  logic [3*COLOR_DEPTH-1:0]        rgb_in_lower,
  output logic                            hub75_r1,
  output logic                            hub75_g1,
  output logic                            hub75_b1,
  output logic                            hub75_r2,
  output logic                            hub75_g2,
  output logic                            hub75_b2,
  output logic                            hub75_clk,
  output logic                            hub75_lat,
  output logic                            hub75_oe_n,
  output logic [$clog2(PANEL_ROWS/2)-1:0] hub75_addr
);
  localparam int SR = PANEL_ROWS / 2;
  localparam int AW = $clog2(SR);
  localparam int PW = $clog2(COLOR_DEPTH);
  localparam int KW = $clog2(PANEL_COLS) + 2;
  localparam int TW = $clog2(BASE_CYCLES << (COLOR_DEPTH - 1)) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(2 * PANEL_COLS);

  shift_state_t shift_state;
  disp_state_t disp_state;
  tag_t tag;
  logic [KW-1:0] k;
  logic [PW-1:0] plane, disp_plane;
  logic [AW-1:0] shift_row;
  logic [COLOR_DEPTH-1:0] ur, ug, ub, lr, lg, lb;
  logic last_plane, timer_load, timer_expired;
  logic [TW-1:0] timer_value;

  assign {ur, ug, ub} = rgb_in_upper;
  assign {lr, lg, lb} = rgb_in_lower;
  assign last_plane = (plane == PW'(COLOR_DEPTH - 1));
  assign timer_load = (disp_state == LATCH) || (disp_state == DISPLAY && timer_expired);
  assign timer_value = (disp_state == LATCH) ? TW'(plane_cycles(BASE_CYCLES, int'(disp_plane)) - 1)
                                             : TW'(BLANK_CYCLES - 1);

  led_matrix_bcm_timer #(.W(TW)) timer (
    .clk(clk),
    .rst(rst),
    .load(timer_load),
    .value(timer_value),
    .expired(timer_expired)
  );

  // shift FSM: even steps capture a column (clk low), odd steps raise the panel clock;
  // frame_column runs one column ahead so the framebuffer read latency is hidden
  always_ff @(posedge clk)
    if (rst) begin
      shift_state <= SHIFT;
      k <= '0;
      plane <= '0;
      shift_row <= '0;
      tag <= '0;
      frame_column <= '0;
      line_sync <= 1'b0;
      hub75_clk <= 1'b0;
      {hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2} <= '0;
    end else begin
      line_sync <= 1'b0;
      if (shift_state == WAIT_LATCH) begin
        if (disp_state == LATCH) begin
          shift_state <= SHIFT;
          plane <= last_plane ? '0 : plane + 1'b1;
        end
      end else if (k == K_LAST) begin
        shift_state <= WAIT_LATCH;
        k <= '0;
        hub75_clk <= 1'b0;
        tag <= '{row: ROW_W'(shift_row), plane: PLANE_W'(plane)};
        line_sync <= last_plane;
        if (last_plane) shift_row <= (shift_row == AW'(SR - 1)) ? '0 : shift_row + 1'b1;
      end else begin
        k <= k + 1'b1;
        hub75_clk <= k[0];
        if (!k[0]) begin
          frame_column <= frame_column + 1'b1;
          {hub75_r1, hub75_g1, hub75_b1, hub75_r2, hub75_g2, hub75_b2} <=
            {ur[plane], ug[plane], ub[plane], lr[plane], lg[plane], lb[plane]};
        end
      end
    end

  // display FSM: show the latched plane, blank, then latch once the next plane is fully shifted
  always_ff @(posedge clk)
    if (rst) begin
      disp_state <= BLANK;
      disp_plane <= '0;
      hub75_oe_n <= 1'b1;
      hub75_lat <= 1'b0;
      hub75_addr <= '0;
    end else if (disp_state == LATCH) begin
      disp_state <= DISPLAY;
      hub75_lat <= 1'b0;
      hub75_oe_n <= 1'b0;
    end else if (disp_state == DISPLAY) begin
      if (timer_expired) begin
        disp_state <= BLANK;
        hub75_oe_n <= 1'b1;
      end
    end else if (timer_expired && shift_state == WAIT_LATCH) begin
      disp_state <= LATCH;
      hub75_lat <= 1'b1;
      hub75_addr <= AW'(tag.row);
      disp_plane <= PW'(tag.plane);
    end
endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// tb_led_matrix_scan_driver: directed checks of three driver instances (BASE_CYCLES 32, 1, 256)
module tb_led_matrix_scan_driver;
  import led_matrix_pkg::*;
  localparam logic [20:0] RESET_OUTS = {1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 5'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [3];
  logic line_sync [3], r1 [3], g1 [3], b1 [3], r2 [3], g2 [3], b2 [3], hclk [3], lat [3], oe_n [3];
  logic [5:0] fcol [3];
  logic [4:0] addr [3];
  int vectors = 0, errors = 0;

  function automatic rgb_t fb(logic [5:0] c);
    logic [7:0] v = {2'b00, c};
    return {v, ~v, v ^ 8'h55};
  endfunction

  function automatic logic [5:0] exp_pins(int c, int b);
    logic [7:0] v = 8'(c);
    logic [7:0] w = 8'(c) ^ 8'h55;
    return {v[b], ~v[b], w[b], ~v[b], v[b], ~w[b]};
  endfunction

  function automatic logic [5:0] pins(int d);
    return {r1[d], g1[d], b1[d], r2[d], g2[d], b2[d]};
  endfunction

  function automatic logic [20:0] outs(int d);
    return {line_sync[d], fcol[d], pins(d), hclk[d], lat[d], oe_n[d], addr[d]};
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g
    rgb_t up, lo;
    always @(posedge clk) begin
      up <= fb(fcol[i]);
      lo <= fb(fcol[i]) ^ 24'hFFFFFF;
    end
    led_matrix_scan_driver #(.BASE_CYCLES(i == 0 ? 32 : i == 1 ? 1 : 256)) dut (
      .clk(clk), .rst(rst[i]), .line_sync(line_sync[i]), .frame_column(fcol[i]),
      .rgb_in_upper(up), .rgb_in_lower(lo),
      .hub75_r1(r1[i]), .hub75_g1(g1[i]), .hub75_b1(b1[i]),
      .hub75_r2(r2[i]), .hub75_g2(g2[i]), .hub75_b2(b2[i]),
      .hub75_clk(hclk[i]), .hub75_lat(lat[i]), .hub75_oe_n(oe_n[i]), .hub75_addr(addr[i])
    );
  end

  task automatic restart(int d);
    rst[d] = 1'b1;
    repeat (2) @(negedge clk);
    rst[d] = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (outs(0) !== RESET_OUTS) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: outputs %h, required %h", i, outs(0), RESET_OUTS);
      end
    end
    rst[0] = 1'b0;
    while (hclk[0] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n > 3) begin
      errors++;
      $display("FAIL first_clk_rise: %0d cycles after release, required <= 3", n);
    end
  endtask

  task automatic test_pixel_mapping();
    int idx = 0, n = 0;
    logic prev = 1'b0;
    restart(0);
    while (idx < 128 && n < 2000) begin
      @(negedge clk);
      n++;
      if (hclk[0] && !prev) begin
        vectors++;
        if (pins(0) !== exp_pins(idx % 64, idx / 64)) begin
          errors++;
          $display("FAIL pixel plane %0d col %0d: pins %b, required %b", idx / 64, idx % 64,
                   pins(0), exp_pins(idx % 64, idx / 64));
        end
        idx++;
      end
      prev = hclk[0];
    end
    vectors++;
    if (idx != 128) begin
      errors++;
      $display("FAIL pixel_count: %0d clock rises, required 128", idx);
    end
  endtask

  task automatic test_bcm_timing();
    int run = 0, len = 0, blank = 0, lats = 0, n = 0;
    logic prev_oe = 1'b1;
    restart(0);
    while (run < 8 && n < 20000) begin
      @(negedge clk);
      n++;
      vectors++;
      if (lat[0] && !oe_n[0]) begin
        errors++;
        $display("FAIL lat_oe_overlap at cycle %0d: lat=1 oe_n=0, required not both", n);
      end
      if (!oe_n[0]) begin
        if (prev_oe) begin
          vectors++;
          if (lats != 1 || blank < 2 || addr[0] !== 5'd0) begin
            errors++;
            $display("FAIL bcm_pre plane %0d: lats=%0d blank=%0d addr=%0d, required 1, >=2, 0",
                     run, lats, blank, addr[0]);
          end
        end
        len++;
      end else begin
        if (!prev_oe) begin
          vectors++;
          if (len != (32 << run)) begin
            errors++;
            $display("FAIL bcm_len plane %0d: oe low %0d cycles, required %0d", run, len, 32 << run);
          end
          run++;
          len = 0;
          lats = 0;
          blank = 0;
        end
        if (lat[0]) lats++;
        else blank++;
      end
      prev_oe = oe_n[0];
    end
    vectors++;
    if (run != 8) begin
      errors++;
      $display("FAIL bcm_runs: %0d runs seen, required 8", run);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0, row5 = 0, rises = 0, len = 0;
    logic prev = 1'b0;
    while (n < 60000 && rises < 20) begin
      @(negedge clk);
      n++;
      if (lat[0] && addr[0] == 5'd5) row5++;
      if (row5 == 3 && hclk[0] && !prev) rises++;
      prev = hclk[0];
    end
    vectors++;
    if (rises != 20) begin
      errors++;
      $display("FAIL mid_reset_reach: %0d rises in row 5 plane 3, required 20", rises);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    vectors++;
    if (outs(0) !== RESET_OUTS) begin
      errors++;
      $display("FAIL mid_reset_outputs: %h, required %h", outs(0), RESET_OUTS);
    end
    rst[0] = 1'b0;
    n = 0;
    while (lat[0] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (lat[0] !== 1'b1 || addr[0] !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset_first_latch: lat=%b addr=%0d, required 1 and 0", lat[0], addr[0]);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!oe_n[0]) len++;
    end
    vectors++;
    if (len != 32) begin
      errors++;
      $display("FAIL mid_reset_oe_len: %0d, required 32", len);
    end
  endtask

  task automatic test_row_sequence();
    int lats = 0, syncs = 0, rises = 0, len = 0, runs = 0, n = 0;
    logic prev_clk = 1'b0, prev_oe = 1'b1;
    restart(1);
    while (lats < 264 && n < 40000) begin
      @(negedge clk);
      n++;
      if (hclk[1] && !prev_clk) rises++;
      if (line_sync[1]) begin
        syncs++;
        vectors++;
        if (lat[1] || lats % 8 != 7) begin
          errors++;
          $display("FAIL line_sync: lat=%b after %0d latches, required lat=0 and 7 mod 8", lat[1], lats);
        end
      end
      if (lat[1]) begin
        vectors++;
        if (addr[1] !== 5'((lats / 8) % 32)) begin
          errors++;
          $display("FAIL row_addr latch %0d: %0d, required %0d", lats, addr[1], (lats / 8) % 32);
        end
        vectors++;
        if (rises != 64) begin
          errors++;
          $display("FAIL columns_per_plane latch %0d: %0d rises, required 64", lats, rises);
        end
        rises = 0;
        lats++;
      end
      if (!oe_n[1]) len++;
      else if (!prev_oe) begin
        vectors++;
        if (len != (1 << (runs % 8))) begin
          errors++;
          $display("FAIL stall_oe_len run %0d: %0d, required %0d", runs, len, 1 << (runs % 8));
        end
        runs++;
        len = 0;
      end
      prev_clk = hclk[1];
      prev_oe = oe_n[1];
    end
    vectors++;
    if (lats != 264 || syncs != 33) begin
      errors++;
      $display("FAIL row_seq_count: %0d latches %0d line_syncs, required 264 and 33", lats, syncs);
    end
  endtask

  task automatic test_wait_latch_idle();
    int n = 0, rises = 0, idle = 0, len = 0, lats = 0;
    logic prev = 1'b0;
    logic [5:0] held = '0;
    restart(2);
    while (lats < 2 && n < 2000) begin
      @(negedge clk);
      n++;
      if (lat[2]) lats++;
      if (!oe_n[2]) len++;
      if (lats == 1) begin
        if (hclk[2] && !prev) begin
          rises++;
          held = pins(2);
        end else if (rises == 64) begin
          idle++;
          vectors++;
          if ({hclk[2], pins(2)} !== {1'b0, held}) begin
            errors++;
            $display("FAIL idle_hold cycle %0d: clk/pins %b, required %b", n, {hclk[2], pins(2)}, {1'b0, held});
          end
        end
      end
      prev = hclk[2];
    end
    vectors++;
    if (lats != 2 || rises != 64 || idle < 120) begin
      errors++;
      $display("FAIL idle_summary: lats=%0d rises=%0d idle=%0d, required 2, 64, >=120", lats, rises, idle);
    end
    vectors++;
    if (len != 256) begin
      errors++;
      $display("FAIL long_plane_oe_len: %0d, required 256", len);
    end
  endtask

  initial begin
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    rst[2] = 1'b1;
    test_reset();
    test_pixel_mapping();
    test_bcm_timing();
    test_mid_reset();
    test_row_sequence();
    test_wait_latch_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/led_matrix_scan_driver.md
Name: led_matrix_scan_driver

Overview:
Downstream consumer of the triple-buffered LED matrix framebuffer. Requests pixel pairs (upper and lower half-panel) by column and shifts them into a HUB75 panel using binary-coded modulation (BCM), one bit plane at a time. Drives the panel's latch, output enable and row address. Generates the per-row `line_sync` that advances the framebuffer's read row. Shifting of plane n+1 overlaps the display of plane n.

Parameters:
PANEL_ROWS, 64, physical panel rows; scan rows = PANEL_ROWS/2
PANEL_COLS, 64, pixels per row
COLOR_DEPTH, 8, bits per colour channel = number of BCM planes
BASE_CYCLES, 32, OE-on time of plane 0 in clk cycles; plane b lasts BASE_CYCLES<<b
BLANK_CYCLES, 2, OE-off cycles before each latch

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
line_sync  out  1  1-cycle pulse; framebuffer advances its read row
frame_column  out  $clog2(PANEL_COLS)  column read address to framebuffer
rgb_in_upper  in  3*COLOR_DEPTH  {R,G,B} of upper-half pixel; valid 1 cycle after frame_column
rgb_in_lower  in  3*COLOR_DEPTH  {R,G,B} of lower-half pixel; same timing
hub75_r1,hub75_g1,hub75_b1  out  1 each  upper-half data bits
hub75_r2,hub75_g2,hub75_b2  out  1 each  lower-half data bits
hub75_clk  out  1  panel shift clock (clk/2)
hub75_lat  out  1  latch pulse, active-high
hub75_oe_n  out  1  output enable, active-low
hub75_addr  out  $clog2(PANEL_ROWS/2)  scan row address

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high. Every output is registered.
- Reset values: line_sync=0, frame_column=0, all data bits=0, hub75_clk=0, hub75_lat=0, hub75_oe_n=1, hub75_addr=0. Internal plane=0, shift_row=0, shift FSM=SHIFT, display FSM=BLANK with the display timer expired.
- Reset asserted at any point aborts the current operation. Outputs take their reset values on the next edge. Operation restarts at row 0, plane 0. The framebuffer is reset together with this block, so the row counters stay aligned.
- Bit select for plane b: r = rgb[2*CD+b], g = rgb[CD+b], b_bit = rgb[b]. Upper-half data drives the *1 pins; lower-half data drives the *2 pins.
- Shift FSM states are SHIFT → WAIT_LATCH → SHIFT.
  - SHIFT: each column takes 2 cycles. frame_column=c is issued one cycle before column c's data phase.
  - Data phase: data bits are updated and hub75_clk=0. The next cycle has hub75_clk=1 with data held.
  - A full plane takes 2*PANEL_COLS cycles, plus 1 cycle of read latency.
- End of a shift:
  - After column PANEL_COLS-1's clk-high cycle, go to WAIT_LATCH.
  - If plane == COLOR_DEPTH-1, pulse line_sync for exactly 1 cycle in that transition cycle. shift_row increments, wrapping at PANEL_ROWS/2-1 → 0.
  - Each shifted plane carries a tag {row, plane} into the display FSM.
- Display FSM states are DISPLAY → BLANK → LATCH → DISPLAY.
  - DISPLAY: hub75_oe_n=0 for exactly BASE_CYCLES<<plane cycles of the currently latched plane.
  - BLANK: hub75_oe_n=1 for BLANK_CYCLES cycles. BLANK exits only when the timer has expired AND the shift FSM is in WAIT_LATCH.
  - LATCH: hub75_lat=1 for exactly 1 cycle with oe_n=1. In the same cycle, hub75_addr takes the tag row. The tagged plane becomes the displayed plane. The shift FSM is released to SHIFT for the next plane (plane+1 mod COLOR_DEPTH).
- Stall rules:
  - Shift longer than display: oe_n stays 1 in BLANK until the shift completes. No data is lost.
  - Display longer than shift: the shift FSM idles in WAIT_LATCH. hub75_clk=0, and data bits hold their last value.
- The first latch after reset occurs as soon as plane 0 of row 0 has shifted; no display precedes it.
- Timer width is $clog2(BASE_CYCLES<<(COLOR_DEPTH-1))+1 bits. No wrap within a plane.
- hub75_lat and hub75_oe_n=0 are never asserted in the same cycle. hub75_clk toggles only in SHIFT.

Decomposition:
- Package led_matrix_pkg:
  - localparams for scan-row count and timer width
  - function plane_cycles(b)
  - typedefs for rgb_t and the {row,plane} latch tag
  - enum typedefs for the shift and display states
- One sub-module, led_matrix_bcm_timer: loadable down-counter with an expired flag, used by the display FSM for both DISPLAY and BLANK durations.

Test Plan:
- Reset check: hold rst 5 cycles, then release. During reset: oe_n=1, lat=0, clk=0, addr=0, line_sync=0. First hub75_clk rises at most 3 cycles after release.
- Pixel mapping: framebuffer model returns upper={R=col, G=~col, B=col^8'h55} and lower=upper^24'hFFFFFF. Capture on each hub75_clk rise for plane b: r1=col[b], g1=~col[b], r2=~col[b], across all 64 columns.
- BCM timing (defaults): oe_n-low run lengths per row are 32, 64, 128 … 4096 in plane order. Each run is preceded by ≥2 blank cycles and exactly 1 lat cycle.
- Row sequencing: exactly one line_sync per 8 planes. hub75_addr sequence is 0, 1 … 31, 0 across a frame. line_sync never coincides with hub75_lat.
- Stall cases:
  - BASE_CYCLES=1: plane 0 OE waits for the 129-cycle shift, with no dropped columns.
  - BASE_CYCLES=256: the shift FSM idles in WAIT_LATCH with hub75_clk=0.
- Mid-operation reset: assert rst at column 20 of plane 3, row 5. Next cycle all outputs are at reset values. After release, the first latched addr=0 and its OE-on length is 32.
